// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and backing-memory signals around the shared port arbiter.
// The slave modport is the arbiter's view; master is the view of the core and memory around it.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  // Instruction-fetch requester
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_kill;
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_rdata;

  // Load/store requester
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [MASK_WIDTH-1:0] d_wmask;
  logic                  d_valid;
  logic [DATA_WIDTH-1:0] d_rdata;

  // Backing memory
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [MASK_WIDTH-1:0] mem_wmask;
  logic                  mem_ready;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, i_kill,
    input  d_req, d_we, d_addr, d_wdata, d_wmask,
    input  mem_ready, mem_rvalid, mem_rdata,
    output i_valid, i_rdata, d_valid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output i_req, i_addr, i_kill,
    output d_req, d_we, d_addr, d_wdata, d_wmask,
    output mem_ready, mem_rvalid, mem_rdata,
    input  i_valid, i_rdata, d_valid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, data first, with a
// starvation counter that bounds fetch delay; one transaction in flight, all outputs registered.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_WIDTH-1:0] STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);

  typedef enum logic [2:0] {IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D, RESP} state_t;

  state_t                state, state_n;
  logic [CNT_WIDTH-1:0]  starve_cnt, starve_n;
  logic                  kill_pend, kill_n;
  logic                  mem_req_q, mem_req_n;
  logic                  mem_we_q, mem_we_n;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_n;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_n;
  logic [MASK_WIDTH-1:0] mem_wmask_q, mem_wmask_n;
  logic                  i_valid_q, i_valid_n;
  logic                  d_valid_q, d_valid_n;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_n;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_n;

  logic fetch_ok, force_i, take_i, take_d;

  // A starved fetch overrides data priority; otherwise data wins whenever it asks.
  assign fetch_ok = bus.i_req & ~bus.i_kill;
  assign force_i  = fetch_ok && (starve_cnt == STARVE_MAX);
  assign take_d   = bus.d_req && !force_i;
  assign take_i   = fetch_ok && !take_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_n     = state;
    starve_n    = starve_cnt;
    kill_n      = kill_pend;
    mem_req_n   = mem_req_q;
    mem_we_n    = mem_we_q;
    mem_addr_n  = mem_addr_q;
    mem_wdata_n = mem_wdata_q;
    mem_wmask_n = mem_wmask_q;
    i_valid_n   = 1'b0;
    d_valid_n   = 1'b0;
    i_rdata_n   = i_rdata_q;
    d_rdata_n   = d_rdata_q;

    unique case (state)
      IDLE: begin
        if (take_i) begin
          state_n     = ISSUE_I;
          mem_req_n   = 1'b1;
          mem_we_n    = 1'b0;
          mem_addr_n  = bus.i_addr;
          mem_wdata_n = '0;
          mem_wmask_n = '0;
          starve_n    = '0;
        end else if (take_d) begin
          state_n     = ISSUE_D;
          mem_req_n   = 1'b1;
          mem_we_n    = bus.d_we;
          mem_addr_n  = bus.d_addr;
          mem_wdata_n = bus.d_wdata;
          mem_wmask_n = bus.d_we ? bus.d_wmask : '0;
          if (!fetch_ok)                  starve_n = '0;
          else if (starve_cnt != STARVE_MAX) starve_n = starve_cnt + 1'b1;
        end else begin
          starve_n = '0;
        end
      end
      ISSUE_I: begin
        if (bus.i_kill) kill_n = 1'b1;
        if (bus.mem_ready) begin
          mem_req_n = 1'b0;
          state_n   = WAIT_I;
        end
      end
      ISSUE_D: begin
        if (bus.mem_ready) begin
          mem_req_n = 1'b0;
          state_n   = WAIT_D;
        end
      end
      WAIT_I: begin
        if (bus.i_kill) kill_n = 1'b1;
        if (bus.mem_rvalid) begin
          // Data is still captured for a killed fetch; only the pulse is withheld.
          i_rdata_n = bus.mem_rdata;
          i_valid_n = ~(kill_pend | bus.i_kill);
          kill_n    = 1'b0;
          state_n   = RESP;
        end
      end
      WAIT_D: begin
        if (bus.mem_rvalid) begin
          d_rdata_n = bus.mem_rdata;
          d_valid_n = 1'b1;
          state_n   = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      kill_pend   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state       <= state_n;
      starve_cnt  <= starve_n;
      kill_pend   <= kill_n;
      mem_req_q   <= mem_req_n;
      mem_we_q    <= mem_we_n;
      mem_addr_q  <= mem_addr_n;
      mem_wdata_q <= mem_wdata_n;
      mem_wmask_q <= mem_wmask_n;
      i_valid_q   <= i_valid_n;
      d_valid_q   <= d_valid_n;
      i_rdata_q   <= i_rdata_n;
      d_rdata_q   <= d_rdata_n;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign bus.i_valid   = i_valid_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transactions against a small memory
// model, then hand-written sequences for starvation, fetch kill and mid-transaction reset.
module tb_mem_port_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: no DUT response within cycle budget", name);
  endtask

  // Backing memory: mem_ready/mem_rvalid driven on the falling edge, sampled by the DUT on the rising one.
  logic [31:0] mem_data [logic [31:0]];
  logic [31:0] grant_log [$];
  int          stall_left = 0;
  bit          acc = 1'b0;
  logic [31:0] acc_addr, acc_wdata;
  logic        acc_we;
  logic [3:0]  acc_wmask;

  initial begin
    logic [31:0] cur;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (rst) begin
        acc = 1'b0;
      end else if (acc) begin
        acc = 1'b0;
        bus.mem_rvalid = 1'b1;
        cur = mem_data.exists(acc_addr) ? mem_data[acc_addr] : 32'h0;
        if (acc_we) begin
          for (int b = 0; b < 4; b++)
            if (acc_wmask[b]) cur[8*b +: 8] = acc_wdata[8*b +: 8];
          mem_data[acc_addr] = cur;
          bus.mem_rdata = 32'h0;
        end else begin
          bus.mem_rdata = cur;
        end
      end else if (bus.mem_req) begin
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          bus.mem_ready = 1'b1;
          acc       = 1'b1;
          acc_addr  = bus.mem_addr;
          acc_we    = bus.mem_we;
          acc_wdata = bus.mem_wdata;
          acc_wmask = bus.mem_wmask;
          grant_log.push_back(bus.mem_addr);
        end
      end
    end
  end

  // The two response pulses must never coincide.
  always @(negedge clk)
    if (!rst) check("valid_exclusive", 64'(bus.i_valid & bus.d_valid), 64'h0);

  typedef struct {
    logic        fetch;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          stall;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_wmask;
  } vec_t;

  // Drives one request at a falling edge; cycle k counts falling edges after the drive.
  task automatic do_txn(input vec_t v, input string tag);
    bit got;
    int exp_lat;
    got     = 1'b0;
    exp_lat = 3 + v.stall;
    @(negedge clk);
    stall_left = v.stall;
    if (v.fetch) begin
      bus.i_req  = 1'b1;
      bus.i_addr = v.addr;
    end else begin
      bus.d_req   = 1'b1;
      bus.d_we    = v.we;
      bus.d_addr  = v.addr;
      bus.d_wdata = v.wdata;
      bus.d_wmask = v.wmask;
    end
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check({tag, "/mem_req"},   64'(bus.mem_req),   64'h1);
        check({tag, "/mem_we"},    64'(bus.mem_we),    64'(v.fetch ? 1'b0 : v.we));
        check({tag, "/mem_wmask"}, 64'(bus.mem_wmask), 64'(v.exp_wmask));
      end
      if (k <= 1 + v.stall) begin
        check({tag, "/mem_addr"}, 64'(bus.mem_addr), 64'(v.addr));
        if (!v.fetch && v.we) check({tag, "/mem_wdata"}, 64'(bus.mem_wdata), 64'(v.wdata));
      end
      if (v.fetch ? bus.i_valid : bus.d_valid) begin
        got = 1'b1;
        check({tag, "/latency"}, 64'(k), 64'(exp_lat));
        if (v.fetch)    check({tag, "/i_rdata"}, 64'(bus.i_rdata), 64'(v.exp_rdata));
        else if (!v.we) check({tag, "/d_rdata"}, 64'(bus.d_rdata), 64'(v.exp_rdata));
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
      end
    end
    if (!got) begin
      timeout_fail({tag, "/timeout"});
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
    end
    @(negedge clk);
    check({tag, "/pulse_width"}, 64'(v.fetch ? bus.i_valid : bus.d_valid), 64'h0);
  endtask

  vec_t vecs [9];

  initial begin
    bit          seen;
    logic [31:0] exp_grant [10];
    logic [7:0]  resp_log [$];
    logic [7:0]  exp_resp;
    int          n_before;
    vec_t        v;

    bus.i_req = 0; bus.i_addr = 0; bus.i_kill = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_wmask = 0;

    mem_data[32'h100] = 32'hDEADBEEF;
    mem_data[32'h104] = 32'hAABBCCDD;
    mem_data[32'h040] = 32'h00000013;
    mem_data[32'h080] = 32'h00100093;

    //         fetch we  addr       wdata         wmask stall exp_rdata     exp_wmask
    vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0,        4'h0, 0, 32'hDEADBEEF, 4'h0};
    vecs[1] = '{1'b0, 1'b1, 32'h104, 32'h12345678, 4'h3, 0, 32'h0,        4'h3};
    vecs[2] = '{1'b0, 1'b0, 32'h104, 32'h0,        4'h0, 0, 32'hAABB5678, 4'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h040, 32'h0,        4'h0, 0, 32'h00000013, 4'h0};
    vecs[4] = '{1'b0, 1'b0, 32'h100, 32'h0,        4'h0, 3, 32'hDEADBEEF, 4'h0};
    vecs[5] = '{1'b0, 1'b0, 32'h108, 32'h0,        4'hF, 0, 32'h0,        4'h0};
    vecs[6] = '{1'b0, 1'b1, 32'h108, 32'hCAFEF00D, 4'hF, 1, 32'h0,        4'hF};
    vecs[7] = '{1'b0, 1'b0, 32'h108, 32'h0,        4'h0, 0, 32'hCAFEF00D, 4'h0};
    vecs[8] = '{1'b1, 1'b0, 32'h104, 32'h0,        4'h0, 2, 32'hAABB5678, 4'h0};

    // Reset, then five idle cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= bus.mem_req | bus.i_valid | bus.d_valid;
    end
    check("idle/any_activity", 64'(seen), 64'h0);
    check("reset/mem_we",    64'(bus.mem_we),    64'h0);
    check("reset/mem_addr",  64'(bus.mem_addr),  64'h0);
    check("reset/mem_wdata", 64'(bus.mem_wdata), 64'h0);
    check("reset/mem_wmask", 64'(bus.mem_wmask), 64'h0);
    check("reset/i_rdata",   64'(bus.i_rdata),   64'h0);
    check("reset/d_rdata",   64'(bus.d_rdata),   64'h0);

    for (int i = 0; i < 9; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Both requesters held: four data grants, then one forced fetch, twice.
    grant_log.delete();
    @(negedge clk);
    stall_left = 0;
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200; bus.d_wmask = 4'h0;
    for (int k = 0; k < 100 && resp_log.size() < 10; k++) begin
      @(negedge clk);
      if (bus.d_valid) resp_log.push_back("D");
      if (bus.i_valid) resp_log.push_back("I");
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    if (resp_log.size() < 10) timeout_fail("starve/timeout");
    for (int g = 0; g < 10; g++) exp_grant[g] = (g % 5 == 4) ? 32'h40 : 32'h200;
    for (int g = 0; g < 10; g++) begin
      exp_resp = (g % 5 == 4) ? "I" : "D";
      check($sformatf("starve/grant%0d", g),
            64'(g < grant_log.size() ? grant_log[g] : 32'hFFFF_FFFF), 64'(exp_grant[g]));
      check($sformatf("starve/resp%0d", g),
            64'(g < resp_log.size() ? resp_log[g] : 8'h0), 64'(exp_resp));
    end
    repeat (2) @(negedge clk);

    // Kill landing in WAIT_I together with the completion.
    n_before = grant_log.size();
    @(negedge clk);
    stall_left = 0;
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    @(negedge clk);
    @(negedge clk);
    bus.i_kill = 1'b1;
    seen = 1'b0;
    @(negedge clk);
    bus.i_kill = 1'b0;
    bus.i_req  = 1'b0;
    seen |= bus.i_valid;
    repeat (5) begin
      @(negedge clk);
      seen |= bus.i_valid;
    end
    check("kill_wait/mem_done", 64'(grant_log.size() - n_before), 64'h1);
    check("kill_wait/i_valid", 64'(seen), 64'h0);
    check("kill_wait/i_rdata", 64'(bus.i_rdata), 64'h00000013);

    // Kill during a stalled ISSUE_I: the held request still completes, response is dropped.
    n_before = grant_log.size();
    @(negedge clk);
    stall_left = 2;
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    @(negedge clk);
    bus.i_kill = 1'b1;
    @(negedge clk);
    bus.i_kill = 1'b0;
    bus.i_req  = 1'b0;
    check("kill_issue/mem_req_held", 64'(bus.mem_req), 64'h1);
    check("kill_issue/mem_addr", 64'(bus.mem_addr), 64'h40);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= bus.i_valid;
    end
    check("kill_issue/mem_done", 64'(grant_log.size() - n_before), 64'h1);
    check("kill_issue/i_valid", 64'(seen), 64'h0);

    v = '{1'b1, 1'b0, 32'h080, 32'h0, 4'h0, 0, 32'h00100093, 4'h0};
    do_txn(v, "fetch_after_kill");

    // Reset while the load waits for its completion.
    @(negedge clk);
    stall_left = 0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.d_req = 1'b0;
    @(negedge clk);
    check("rst_mid/mem_req",   64'(bus.mem_req),   64'h0);
    check("rst_mid/mem_we",    64'(bus.mem_we),    64'h0);
    check("rst_mid/mem_addr",  64'(bus.mem_addr),  64'h0);
    check("rst_mid/mem_wdata", 64'(bus.mem_wdata), 64'h0);
    check("rst_mid/mem_wmask", 64'(bus.mem_wmask), 64'h0);
    check("rst_mid/i_valid",   64'(bus.i_valid),   64'h0);
    check("rst_mid/d_valid",   64'(bus.d_valid),   64'h0);
    check("rst_mid/i_rdata",   64'(bus.i_rdata),   64'h0);
    check("rst_mid/d_rdata",   64'(bus.d_rdata),   64'h0);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= bus.d_valid | bus.mem_req;
    end
    check("rst_mid/no_late_response", 64'(seen), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
